int2float_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational 11-bit-integer-to-7-bit-float converter among NREQ requesters. It accepts one request per cycle over valid/ready and presents each operand to the converter from a registered stage. It captures the converter result together with the requester index into an output register with backpressure. It sits between the operand producers and the single converter instance, which it drives but does not contain.

---
 rtl/int2float_arbiter.sv | 132 +++++++++++++
 tb/tb_int2float_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/int2float_arbiter.sv
// Round-robin front end for one shared int-to-float converter.
// A registered operand stage feeds the converter; a result register applies backpressure.
module int2float_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [11*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [10:0]       conv_in,
  input  logic [6:0]        conv_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_data,
  output logic [IDW-1:0]    out_id,
  output logic              busy,
  output logic [15:0]       done_count
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q, s1_valid_d;
  logic [10:0]    s1_data_q, s1_data_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           out_valid_q, out_valid_d;
  logic [6:0]     out_data_q, out_data_d;
  logic [IDW-1:0] out_id_q, out_id_d;
  logic [15:0]    done_q, done_d;

  logic [10:0]    ops [NREQ];
  logic [IDW:0]   scan;
  logic [IDW:0]   nxt;
  logic           hit;
  logic [IDW-1:0] gidx;
  logic           s2_free, s1_free;
  logic           adv, grant, hs;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign ops[g] = req_data[11*g +: 11];
  end

  assign s2_free = !out_valid_q | out_ready;
  assign s1_free = !s1_valid_q | s2_free;
  assign adv     = s1_valid_q & s2_free;
  assign hs      = out_valid_q & out_ready;
  assign grant   = hit & s1_free & !rst;

  // First valid requester at or after ptr, wrapping at NREQ.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    scan = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!hit && req_valid[scan[IDW-1:0]]) begin
        hit  = 1'b1;
        gidx = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gidx} + (IDW+1)'(1);
    if (nxt >= NREQ_W) nxt = '0;
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gidx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    done_d      = done_q;
    if (grant) begin
      s1_valid_d = 1'b1;
      s1_data_d  = ops[gidx];
      s1_id_d    = gidx;
      ptr_d      = nxt[IDW-1:0];
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end
    if (adv) begin
      out_valid_d = 1'b1;
      out_data_d  = conv_out;
      out_id_d    = s1_id_q;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
    if (hs) done_d = done_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      done_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      done_q      <= done_d;
    end
  end

  assign conv_in    = s1_data_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;
  assign busy       = s1_valid_q | out_valid_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_int2float_arbiter.sv
// Directed bench for int2float_arbiter.
// The shared converter is a fixed golden function of conv_in.
module tb_int2float_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [43:0] req_data;
  logic [3:0]  req_ready;
  logic [10:0] conv_in;
  logic [6:0]  conv_out;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [1:0]  out_id;
  logic        busy;
  logic [15:0] done_count;

  int npass = 0;
  int ntotal = 0;
  int prev;
  int g;
  int hs;
  int cyc;
  logic [10:0] dv [4];

  always #5 clk = ~clk;

  function automatic logic [6:0] f(input logic [10:0] x);
    return x[10:4] ^ x[6:0];
  endfunction

  assign conv_out = f(conv_in);

  int2float_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready),
    .conv_in(conv_in), .conv_out(conv_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .busy(busy), .done_count(done_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [10:0] v);
    req_data[11*i +: 11] = v;
    dv[i] = v;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) setd(i, 11'(i + 1));
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ovalid", 32'(out_valid), 32'h0);
    chk("rst_odata", 32'(out_data), 32'h0);
    chk("rst_oid", 32'(out_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done_count), 32'h0);
    chk("rst_convin", 32'(conv_in), 32'h0);

    // single request from requester 2
    rst = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    tick();
    setd(2, 11'd1000);
    req_valid = 4'b0100;
    #1;
    chk("one_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("one_convin", 32'(conv_in), 32'd1000);
    chk("one_ov0", 32'(out_valid), 32'h0);
    chk("one_busy", 32'(busy), 32'h1);
    tick();
    chk("one_ov1", 32'(out_valid), 32'h1);
    chk("one_id", 32'(out_id), 32'd2);
    chk("one_data", 32'(out_data), 32'd86);
    chk("one_done0", 32'(done_count), 32'd0);
    tick();
    chk("one_done1", 32'(done_count), 32'd1);
    chk("one_idle", 32'(busy), 32'h0);

    // ptr is 3; only requester 1 valid
    setd(1, 11'd5);
    req_valid = 4'b0010;
    #1;
    chk("skip_ready1", 32'(req_ready), 32'h2);
    tick();
    setd(0, 11'd100);
    setd(1, 11'd200);
    setd(2, 11'd300);
    setd(3, 11'd400);
    req_valid = 4'b1111;
    #1;
    chk("skip_ready2", 32'(req_ready), 32'h4);
    tick();
    chk("skip_oid", 32'(out_id), 32'd1);
    chk("skip_odata", 32'(out_data), 32'(f(11'd5)));

    // fairness: grants continue 3,0,1,2,3,0,1,2,3
    prev = 2;
    for (int k = 0; k < 9; k++) begin
      g = (3 + k) % 4;
      chk("rr_ready", 32'(req_ready), 32'(1 << g));
      tick();
      chk("rr_oid", 32'(out_id), 32'(prev));
      chk("rr_odata", 32'(out_data), 32'(f(dv[prev])));
      chk("rr_ov", 32'(out_valid), 32'h1);
      prev = g;
    end
    req_valid = 4'b0000;
    tick();
    chk("rr_last", 32'(out_id), 32'd3);
    tick();
    chk("rr_done", 32'(done_count), 32'd12);
    chk("rr_idle", 32'(busy), 32'h0);

    // backpressure with three queued requests
    out_ready = 1'b0;
    setd(0, 11'd7);
    setd(1, 11'd2047);
    setd(2, 11'd1024);
    req_valid = 4'b0111;
    #1;
    chk("bp_r0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0110;
    #1;
    chk("bp_r1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("bp_full", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      chk("bp_hold_id", 32'(out_id), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'(f(11'd7)));
      chk("bp_hold_conv", 32'(conv_in), 32'd2047);
      chk("bp_hold_busy", 32'(busy), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_r2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("bp_o1_id", 32'(out_id), 32'd1);
    chk("bp_o1_data", 32'(out_data), 32'(f(11'd2047)));
    tick();
    chk("bp_o2_id", 32'(out_id), 32'd2);
    chk("bp_o2_data", 32'(out_data), 32'(f(11'd1024)));
    tick();
    chk("bp_drain", 32'(out_valid), 32'h0);
    chk("bp_done", 32'(done_count), 32'd15);

    // reset with both stages occupied
    out_ready = 1'b0;
    setd(0, 11'd50);
    setd(1, 11'd60);
    req_valid = 4'b0011;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    chk("mid_full", 32'(busy), 32'h1);
    chk("mid_ov", 32'(out_valid), 32'h1);
    rst = 1'b1;
    tick();
    chk("mid_ov0", 32'(out_valid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_done", 32'(done_count), 32'd0);
    chk("mid_conv", 32'(conv_in), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_stale", 32'(out_valid), 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'h1);

    // counter wrap after 65536 handshakes
    hs = 0;
    cyc = 0;
    while (hs < 65536 && cyc < 70000) begin
      if (out_valid) hs = hs + 1;
      tick();
      cyc = cyc + 1;
      if (hs == 65535 && out_valid)
        chk("wrap_ffff", 32'(done_count), 32'hFFFF);
    end
    chk("wrap_budget", 32'(hs), 32'd65536);
    chk("wrap_zero", 32'(done_count), 32'd0);
    req_valid = 4'b0000;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
